flash_sample_reader: RTL

- Avalon-MM read initiator that streams 16-bit signed audio samples out of the on-board flash into the audio core for the chipmunks player.
- Sits between the flash IP (flash_mem_* slave) and the audio core's write_ready/write handshake in chipmunks.
- Each 32-bit flash word holds two samples: the low half is played first, then the high half.
- Playback speed is selected by a mode input: normal, chipmunk (2x) or slow (0.5x).

---
 rtl/flash_sample_reader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/flash_sample_reader.sv
// Avalon-MM read initiator: fetches 32-bit flash words and plays their two
// 16-bit signed halves (low first) into the audio core, scaled by VOL_SHIFT.
module flash_sample_reader #(
    parameter int NUM_WORDS = 1048576,
    parameter int VOL_SHIFT = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    input  logic        flash_mem_waitrequest,
    input  logic [31:0] flash_mem_readdata,
    input  logic        flash_mem_readdatavalid,
    output logic        flash_mem_write,
    output logic        flash_mem_burstcount,
    output logic [3:0]  flash_mem_byteenable,
    output logic [31:0] flash_mem_writedata,
    input  logic        write_ready,
    output logic        write,
    output logic [15:0] writedata_left,
    output logic [15:0] writedata_right,
    output logic        wrap_pulse
);

    localparam logic [2:0] RD_REQ   = 3'd0;
    localparam logic [2:0] RD_WAIT  = 3'd1;
    localparam logic [2:0] LOAD     = 3'd2;
    localparam logic [2:0] WAIT_RDY = 3'd3;
    localparam logic [2:0] WRITE    = 3'd4;
    localparam logic [2:0] ADVANCE  = 3'd5;
    localparam logic [2:0] NEXT     = 3'd6;

    localparam logic [1:0] MODE_CHIP = 2'b01;
    localparam logic [1:0] MODE_SLOW = 2'b10;

    localparam logic [22:0] LAST_ADDR = 23'(NUM_WORDS - 1);

    logic [2:0]  r_state;
    logic        r_read;
    logic [22:0] r_addr;
    logic [31:0] r_buf;
    logic [1:0]  r_mode;
    logic        r_half;
    logic        r_rep;
    logic        r_write;
    logic [15:0] r_sample;
    logic        r_wrap;
    logic [15:0] w_sample;

    function automatic logic [15:0] vol_scale(input logic [15:0] s);
        logic signed [15:0] v;
        v = $signed(s) >>> VOL_SHIFT;
        return v;
    endfunction

    assign w_sample = r_half ? r_buf[31:16] : r_buf[15:0];

    assign flash_mem_read       = r_read;
    assign flash_mem_address    = r_addr;
    assign flash_mem_write      = 1'b0;
    assign flash_mem_burstcount = 1'b1;
    assign flash_mem_byteenable = 4'hF;
    assign flash_mem_writedata  = 32'd0;
    assign write                = r_write;
    assign writedata_left       = r_sample;
    assign writedata_right      = r_sample;
    assign wrap_pulse           = r_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RD_REQ;
            r_read   <= 1'b0;
            r_addr   <= 23'd0;
            r_buf    <= 32'd0;
            r_mode   <= 2'b00;
            r_half   <= 1'b0;
            r_rep    <= 1'b0;
            r_write  <= 1'b0;
            r_sample <= 16'd0;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                RD_REQ: begin
                    if (!r_read) begin
                        r_read <= 1'b1;
                    end else if (!flash_mem_waitrequest) begin
                        r_read <= 1'b0;
                        // zero-latency slave: data may arrive with the accept
                        if (flash_mem_readdatavalid) begin
                            r_buf   <= flash_mem_readdata;
                            r_mode  <= mode;
                            r_half  <= 1'b0;
                            r_rep   <= 1'b0;
                            r_state <= LOAD;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (flash_mem_readdatavalid) begin
                        r_buf   <= flash_mem_readdata;
                        r_mode  <= mode;
                        r_half  <= 1'b0;
                        r_rep   <= 1'b0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_sample <= vol_scale(w_sample);
                    r_state  <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (write_ready) begin
                        r_write <= 1'b1;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (!write_ready) begin
                        r_write <= 1'b0;
                        r_state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    case (r_mode)
                        MODE_CHIP: r_state <= NEXT;
                        MODE_SLOW: begin
                            if (!r_rep) begin
                                r_rep   <= 1'b1;
                                r_state <= LOAD;
                            end else begin
                                r_rep <= 1'b0;
                                if (!r_half) begin
                                    r_half  <= 1'b1;
                                    r_state <= LOAD;
                                end else begin
                                    r_state <= NEXT;
                                end
                            end
                        end
                        default: begin
                            if (!r_half) begin
                                r_half  <= 1'b1;
                                r_state <= LOAD;
                            end else begin
                                r_state <= NEXT;
                            end
                        end
                    endcase
                end
                NEXT: begin
                    if (r_addr == LAST_ADDR) begin
                        r_addr <= 23'd0;
                        r_wrap <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 23'd1;
                    end
                    r_read  <= 1'b1;
                    r_state <= RD_REQ;
                end
                default: r_state <= RD_REQ;
            endcase
        end
    end

endmodule
